// File: rtl/fifo_8x8.sv
// fifo_8x8: single-clock FIFO with registered read data, a one-cycle valid
// pulse, occupancy flags and sticky overflow/underflow error bits.
// Flags are decoded from the registered count only, so a write to an empty
// FIFO cannot be read in the same cycle and a read from a full FIFO does not
// free a slot for a same-cycle write.
module fifo_8x8 #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       udf,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage carries no reset so it can map onto block RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [CW-1:0] count_next;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Acceptance uses the pre-edge flags: no bypass in either direction.
    assign wr_ok = we && !full;
    assign rd_ok = re && !empty;

    // Occupancy after this edge: +1 for an accepted write, -1 for an accepted read.
    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Storage write port; rejected writes leave memory untouched.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_reg] <= wdata;
        end
    end

    // Pointers and count; pointers wrap modulo DEPTH by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            count    <= '0;
        end else begin
            if (wr_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            count <= count_next;
        end
    end

    // Registered read port: rdata holds its last value when no pop is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_ok;
            if (rd_ok) begin
                rdata <= mem[rptr_reg];
            end
        end
    end

    // Sticky error bits; a new violation outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (we && full) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (re && empty) begin
                udf <= 1'b1;
            end else if (clr_err) begin
                udf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fifo_8x8.md
# fifo_8x8

Synchronous single-clock FIFO (default 8 entries × 8 bits) that provides the read side for the write-enable/write-data producers already in the Basys3 design. Producers push with a write strobe exactly as they load a register. A consumer pops with a read strobe and receives registered data qualified by a valid pulse. Status flags and sticky error bits let the top level detect flow-control violations.

## Interface

Parameters:
- DEPTH, 8, number of entries; must be a power of two, ≥2
- WIDTH, 8, data width in bits

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous assert, active-low (0 = reset); one clock, asynchronous active-low reset
- we  input  1  write strobe; push wdata when accepted
- wdata  input  WIDTH  write data
- re  input  1  read strobe; pop head entry when accepted
- rdata  output  WIDTH  registered read data
- rvalid  output  1  high for exactly one cycle when rdata carries a newly popped word
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- ovf  output  1  sticky overflow: write attempted while full
- udf  output  1  sticky underflow: read attempted while empty
- clr_err  input  1  synchronous clear of ovf and udf

## Operation

- Storage: DEPTH × WIDTH array. Storage is not reset. Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH naturally (DEPTH-1 → 0).
- Write acceptance: wr_ok = we && !full. On wr_ok, mem[wptr] <= wdata and wptr increments.
- Read acceptance: rd_ok = re && !empty. On rd_ok, rdata <= mem[rptr], rvalid <= 1 and rptr increments.
- rvalid: when rd_ok is low, rvalid <= 0 and rdata holds its previous value.
- Flag source: full, empty and count are based on the registered state before the edge. There is no bypass:
  - A write to an empty FIFO cannot be read in the same cycle.
  - A read from a full FIFO does not free a slot for a same-cycle write.
- Simultaneous we && re with 0 < count < DEPTH: both are accepted and count is unchanged.
- Simultaneous we && re at empty: only the write is accepted, count becomes 1, udf sets.
- Simultaneous we && re at full: only the read is accepted, count becomes DEPTH-1, ovf sets.
- count update: count <= count + wr_ok − rd_ok. It never exceeds DEPTH and never goes below 0.
- ovf and udf:
  - ovf <= 1 on we && full; udf <= 1 on re && empty.
  - Rejected operations change no pointer, count or storage.
  - clr_err clears both bits. If a set condition and clr_err occur in the same cycle, the set wins.
- Reset (rst = 0, any time, including mid-operation):
  - wptr, rptr and count go to 0; empty = 1, full = 0.
  - rdata = 0, rvalid = 0, ovf = 0, udf = 0.
  - Stored contents become unreachable.
  - On reset release, the first accepted write lands at entry 0.

## Timing

- All outputs are registered or decoded from registered count. None depends combinationally on we or re.
- Write-to-read latency: a word written at edge N updates count/empty after edge N. re asserted in the following cycle is accepted at edge N+1, and rdata/rvalid are valid after edge N+1.
- Read latency: one cycle from the accepting edge. rvalid is high in the cycle following the accepting edge only.
- Back-to-back throughput: re held high returns one word per clock until empty, with rvalid continuously high. The cycle after the last pop has rvalid = 0 unless another pop is accepted.
- Flag timing: full, empty and count reflect the result of the previous edge's accepted operations.
- Reset: asynchronous assertion takes effect immediately. Deassertion should be synchronized at top level; the block requires no extra cycles after release.

## Test plan

- Reset values: hold rst = 0, toggle we/re → count = 0, empty = 1, full = 0, rdata = 0x00, rvalid = 0, ovf = udf = 0. Release, then write 0xA5 and read → rdata = 0xA5 with rvalid one cycle after the read edge.
- Fill and drain: write 0x01..0x08 (DEPTH = 8) → full = 1, count = 8. A 9th write of 0xFF → ovf = 1, count stays 8. Read 8 times → rdata sequence 0x01..0x08, empty = 1. A 9th read → udf = 1, rvalid = 0, rdata holds 0x08.
- Wrap-around: repeat "write 5 words, read 5 words" three times with distinct data → all 15 words returned in order, count returns to 0, no flags set.
- Simultaneous operations:
  - At count = 3, assert we and re together for 4 cycles → count stays 3 and output order is preserved.
  - At empty, we+re → count = 1, udf = 1.
  - At full, we+re → count = 7, ovf = 1, the rejected word never appears.
- Error clear: with ovf = udf = 1, pulse clr_err → both 0. Pulse clr_err together with a write to a full FIFO → ovf remains 1.
- Reset mid-operation: at count = 5 with a read in flight, assert rst = 0 asynchronously between edges → outputs go to reset values immediately. After release, write 0x3C and read → rdata = 0x3C.
